// File: rtl/lock.sv
// Four-digit keypad lock with per-digit progress, failed-attempt counter
// and optional lockout alarm.
// Optional feature macro: LOCK_LOCKOUT_EN (adds the ALARM state and drives
// buzzer; without it buzzer is tied low and entry is never blocked).
//
//   state | meaning
//   IDLE  | waiting for start; index and progress cleared
//   ENTRY | collecting digits, idx_q selects the code nibble expected next
//   OPEN  | code accepted, out held high until start drops
//   ALARM | lockout, only reset leaves it (LOCK_LOCKOUT_EN builds only)
module lock #(
    parameter logic [15:0] CODE      = 16'hBFDC,
    parameter int          MAX_TRIES = 3
) (
    input  logic [3:0] digit,
    input  logic       start,
    input  logic       reset,
    input  logic       clk,
    output logic       out,
    output logic       buzzer,
    output logic [2:0] count,
    output logic [3:0] cp,
    output logic [3:0] ci
);

    if (MAX_TRIES < 1 || MAX_TRIES > 7) begin : g_bad_tries
        $error("lock: MAX_TRIES must be in 1..7");
    end
    if (CODE[15:12] == 4'hA || CODE[11:8] == 4'hA ||
        CODE[7:4] == 4'hA || CODE[3:0] == 4'hA) begin : g_bad_code
        $error("lock: no code nibble may equal the clear key 4'hA");
    end

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        OPEN
`ifdef LOCK_LOCKOUT_EN
        , ALARM
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] sync_q;
    logic       live;
    logic       out_d, buzzer_d;
    logic [2:0] count_d, count_inc;
    logic [3:0] cp_d, ci_d, expected;

    // Release synchronizer: async assert, two-stage release. Stage 0 already
    // enables the FSM, so the second rising edge after release is the first
    // active one; stage 1 keeps the enable held once the chain has settled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], 1'b1};
    end

    assign live = sync_q[0] | sync_q[1];

    // Code nibble expected at the current entry position (digit0 is the MSN).
    always_comb begin
        expected = CODE[15:12];
        case (idx_q)
            2'd0: expected = CODE[15:12];
            2'd1: expected = CODE[11:8];
            2'd2: expected = CODE[7:4];
            2'd3: expected = CODE[3:0];
            default: expected = CODE[15:12];
        endcase
    end

    assign count_inc = (count == 3'd7) ? 3'd7 : count + 3'd1;

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        out_d    = out;
        buzzer_d = buzzer;
        count_d  = count;
        cp_d     = cp;
        ci_d     = ci;
        if (live) begin
            case (state_q)
                IDLE, ENTRY: begin
                    if (start) begin
                        ci_d = digit;
                        if (digit == expected) begin
                            cp_d = cp | (4'b0001 << idx_q);
                            if (idx_q == 2'd3) begin
                                state_d = OPEN;
                                out_d   = 1'b1;
                                count_d = 3'd0;
                                idx_d   = 2'd0;
                            end else begin
                                state_d = ENTRY;
                                idx_d   = idx_q + 2'd1;
                            end
                        end else if (digit == 4'hA) begin
                            state_d = ENTRY;
                            idx_d   = 2'd0;
                            cp_d    = 4'h0;
                        end else begin
                            state_d = ENTRY;
                            idx_d   = 2'd0;
                            cp_d    = 4'h0;
                            count_d = count_inc;
`ifdef LOCK_LOCKOUT_EN
                            if (count_inc == 3'(MAX_TRIES)) begin
                                state_d  = ALARM;
                                buzzer_d = 1'b1;
                            end
`endif
                        end
                    end else begin
                        state_d = IDLE;
                        idx_d   = 2'd0;
                        cp_d    = 4'h0;
                    end
                end
                OPEN: begin
                    if (start) begin
                        ci_d = digit;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 2'd0;
                        out_d   = 1'b0;
                        cp_d    = 4'h0;
                    end
                end
`ifdef LOCK_LOCKOUT_EN
                ALARM: begin
                    state_d = ALARM;
                end
`endif
                default: begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    out_d   = 1'b0;
                    cp_d    = 4'h0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            out     <= 1'b0;
            buzzer  <= 1'b0;
            count   <= 3'd0;
            cp      <= 4'h0;
            ci      <= 4'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            out     <= out_d;
`ifdef LOCK_LOCKOUT_EN
            buzzer  <= buzzer_d;
`else
            buzzer  <= 1'b0;
`endif
            count   <= count_d;
            cp      <= cp_d;
            ci      <= ci_d;
        end
    end

`ifndef LOCK_LOCKOUT_EN
    logic unused_buzzer_d;
    assign unused_buzzer_d = buzzer_d;
`endif

endmodule

// File: tb/tb_lock.sv
// Directed bench for the keypad lock: a vector table for the main entry
// sequences plus hand-written reset and lockout/saturation sequences.
module tb_lock;

    logic [3:0] digit;
    logic       start;
    logic       reset;
    logic       clk;
    logic       out;
    logic       buzzer;
    logic [2:0] count;
    logic [3:0] cp;
    logic [3:0] ci;

    int n_vec = 0;
    int n_mis = 0;

    lock #(.CODE(16'hBFDC), .MAX_TRIES(3)) dut (
        .digit(digit), .start(start), .reset(reset), .clk(clk),
        .out(out), .buzzer(buzzer), .count(count), .cp(cp), .ci(ci)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [3:0] digit;
        logic       out_e;
        logic       buz_e;
        logic [2:0] cnt_e;
        logic [3:0] cp_e;
        logic [3:0] ci_e;
    } vec_t;

    vec_t vecs[31];

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic o, input logic b,
                           input logic [2:0] c, input logic [3:0] p, input logic [3:0] i);
        chk({tag, ".out"},    {3'b0, out},    {3'b0, o});
        chk({tag, ".buzzer"}, {3'b0, buzzer}, {3'b0, b});
        chk({tag, ".count"},  {1'b0, count},  {1'b0, c});
        chk({tag, ".cp"},     cp,             p);
        chk({tag, ".ci"},     ci,             i);
    endtask

    task automatic step(input logic s, input logic [3:0] d);
        @(negedge clk);
        start = s;
        digit = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 4'hB, 1'b0, 1'b0, 3'd0, 4'h1, 4'hB};
        vecs[1]  = '{1'b1, 4'hF, 1'b0, 1'b0, 3'd0, 4'h3, 4'hF};
        vecs[2]  = '{1'b1, 4'hD, 1'b0, 1'b0, 3'd0, 4'h7, 4'hD};
        vecs[3]  = '{1'b1, 4'hC, 1'b1, 1'b0, 3'd0, 4'hF, 4'hC};
        vecs[4]  = '{1'b1, 4'h5, 1'b1, 1'b0, 3'd0, 4'hF, 4'h5};
        vecs[5]  = '{1'b0, 4'h5, 1'b0, 1'b0, 3'd0, 4'h0, 4'h5};
        vecs[6]  = '{1'b1, 4'hB, 1'b0, 1'b0, 3'd0, 4'h1, 4'hB};
        vecs[7]  = '{1'b1, 4'hF, 1'b0, 1'b0, 3'd0, 4'h3, 4'hF};
        vecs[8]  = '{1'b1, 4'h0, 1'b0, 1'b0, 3'd1, 4'h0, 4'h0};
        vecs[9]  = '{1'b1, 4'hB, 1'b0, 1'b0, 3'd1, 4'h1, 4'hB};
        vecs[10] = '{1'b1, 4'hF, 1'b0, 1'b0, 3'd1, 4'h3, 4'hF};
        vecs[11] = '{1'b1, 4'hD, 1'b0, 1'b0, 3'd1, 4'h7, 4'hD};
        vecs[12] = '{1'b1, 4'hC, 1'b1, 1'b0, 3'd0, 4'hF, 4'hC};
        vecs[13] = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 4'h0, 4'hC};
        vecs[14] = '{1'b1, 4'hB, 1'b0, 1'b0, 3'd0, 4'h1, 4'hB};
        vecs[15] = '{1'b1, 4'hF, 1'b0, 1'b0, 3'd0, 4'h3, 4'hF};
        vecs[16] = '{1'b1, 4'hA, 1'b0, 1'b0, 3'd0, 4'h0, 4'hA};
        vecs[17] = '{1'b1, 4'hB, 1'b0, 1'b0, 3'd0, 4'h1, 4'hB};
        vecs[18] = '{1'b1, 4'hF, 1'b0, 1'b0, 3'd0, 4'h3, 4'hF};
        vecs[19] = '{1'b1, 4'hD, 1'b0, 1'b0, 3'd0, 4'h7, 4'hD};
        vecs[20] = '{1'b1, 4'hC, 1'b1, 1'b0, 3'd0, 4'hF, 4'hC};
        vecs[21] = '{1'b0, 4'h3, 1'b0, 1'b0, 3'd0, 4'h0, 4'hC};
        vecs[22] = '{1'b1, 4'hB, 1'b0, 1'b0, 3'd0, 4'h1, 4'hB};
        vecs[23] = '{1'b0, 4'hB, 1'b0, 1'b0, 3'd0, 4'h0, 4'hB};
        vecs[24] = '{1'b1, 4'hB, 1'b0, 1'b0, 3'd0, 4'h1, 4'hB};
        vecs[25] = '{1'b1, 4'hB, 1'b0, 1'b0, 3'd1, 4'h0, 4'hB};
        vecs[26] = '{1'b1, 4'hB, 1'b0, 1'b0, 3'd1, 4'h1, 4'hB};
        vecs[27] = '{1'b1, 4'hF, 1'b0, 1'b0, 3'd1, 4'h3, 4'hF};
        vecs[28] = '{1'b1, 4'hD, 1'b0, 1'b0, 3'd1, 4'h7, 4'hD};
        vecs[29] = '{1'b1, 4'hC, 1'b1, 1'b0, 3'd0, 4'hF, 4'hC};
        vecs[30] = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 4'h0, 4'hC};

        reset = 1'b0;
        start = 1'b0;
        digit = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset_state", 1'b0, 1'b0, 3'd0, 4'h0, 4'h0);

        // Release; first edge after release must be ignored.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        digit = 4'hB;
        @(posedge clk);
        #1;
        chk_all("sync_edge1", 1'b0, 1'b0, 3'd0, 4'h0, 4'h0);
        step(1'b0, 4'h0);
        chk_all("sync_edge2_idle", 1'b0, 1'b0, 3'd0, 4'h0, 4'h0);

        for (int k = 0; k < 31; k++) begin
            step(vecs[k].start, vecs[k].digit);
            chk_all($sformatf("vec%0d", k), vecs[k].out_e, vecs[k].buz_e,
                    vecs[k].cnt_e, vecs[k].cp_e, vecs[k].ci_e);
        end

        // Async reset mid-entry with a nonzero count.
        step(1'b1, 4'hB);
        step(1'b1, 4'h1);
        step(1'b1, 4'hB);
        step(1'b1, 4'hF);
        chk_all("pre_abort", 1'b0, 1'b0, 3'd1, 4'h3, 4'hF);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_abort", 1'b0, 1'b0, 3'd0, 4'h0, 4'h0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        digit = 4'hB;
        @(posedge clk);
        #1;
        chk_all("abort_edge1", 1'b0, 1'b0, 3'd0, 4'h0, 4'h0);
        step(1'b1, 4'hB);
        chk_all("abort_edge2", 1'b0, 1'b0, 3'd0, 4'h1, 4'hB);
        step(1'b0, 4'h0);
        chk_all("abort_idle", 1'b0, 1'b0, 3'd0, 4'h0, 4'hB);

`ifdef LOCK_LOCKOUT_EN
        step(1'b1, 4'h1);
        chk_all("lock_w1", 1'b0, 1'b0, 3'd1, 4'h0, 4'h1);
        step(1'b1, 4'h2);
        chk_all("lock_w2", 1'b0, 1'b0, 3'd2, 4'h0, 4'h2);
        step(1'b1, 4'h3);
        chk_all("lock_w3", 1'b0, 1'b1, 3'd3, 4'h0, 4'h3);
        step(1'b1, 4'hB);
        step(1'b1, 4'hF);
        step(1'b1, 4'hD);
        step(1'b1, 4'hC);
        chk_all("lock_code_ignored", 1'b0, 1'b1, 3'd3, 4'h0, 4'h3);
        step(1'b0, 4'h0);
        chk_all("lock_start_low", 1'b0, 1'b1, 3'd3, 4'h0, 4'h3);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all("lock_reset", 1'b0, 1'b0, 3'd0, 4'h0, 4'h0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 4'h0);
        step(1'b1, 4'hB);
        chk_all("lock_after_reset", 1'b0, 1'b0, 3'd0, 4'h1, 4'hB);
`else
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 4'h1);
            chk_all($sformatf("sat_w%0d", k), 1'b0, 1'b0,
                    (k > 7) ? 3'd7 : 3'(k), 4'h0, 4'h1);
        end
        step(1'b1, 4'hB);
        step(1'b1, 4'hF);
        step(1'b1, 4'hD);
        chk_all("sat_partial", 1'b0, 1'b0, 3'd7, 4'h7, 4'hD);
        step(1'b1, 4'hC);
        chk_all("sat_open", 1'b1, 1'b0, 3'd0, 4'hF, 4'hC);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
